// File: rtl/seg7_pkg.sv
// Shared constants for the 4-digit common-anode 7-segment scan multiplexer.
// Anode and decimal-point lines are active-low, so "off" is all ones.
// NUM_DIGITS sets the digit index width; BCD_MAX is the largest displayable value.
package seg7_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam int         IDX_W      = $clog2(NUM_DIGITS);
  localparam logic [3:0] AN_OFF     = 4'b1111;
  localparam logic       DP_OFF     = 1'b1;
  localparam logic [3:0] BCD_MAX    = 4'd9;

  // Active-low anode pattern that lights only digit idx.
  function automatic logic [NUM_DIGITS-1:0] anode_sel(input logic [IDX_W-1:0] idx);
    return ~(NUM_DIGITS'(1) << idx);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulus counter: counts 0..MOD-1 while i_en is high, then wraps to 0.
// o_tc is a combinational one-cycle pulse on the enabled terminal count.
// Synchronous active-high reset returns the count to 0.
module mod_counter #(
  parameter int MOD = 8,
  parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_en,
  output logic [W-1:0] o_count,
  output logic         o_tc
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == W'(MOD - 1));
  assign o_tc     = i_en && w_at_max;
  assign o_count  = r_count;

  // Advance when enabled, wrapping to zero at the terminal count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= w_at_max ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/seg7_scan_mux.sv
// Scans four BCD digits onto a shared common-anode display, one digit per slot.
// Outputs are registered: 1 cycle from any state/input to an, dp, bcd_out.
// Each slot opens with a blanking window; blink, enable and non-BCD also blank.
module seg7_scan_mux
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500,
  parameter int BLINK_DIV = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0] blink_mask,
  input  logic [NUM_DIGITS-1:0] dp_mask,
  input  logic                  enable,
  output logic [3:0]            bcd_out,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  dp,
  output logic [IDX_W-1:0]      digit_idx
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PRE_W-1:0] BLANK_END = PRE_W'(BLANK_CYC);

  logic [PRE_W-1:0] w_pre_cnt;
  logic             w_slot_tick;
  logic [BLK_W-1:0] w_unused_blink_cnt;
  logic             w_blink_wrap;
  logic [IDX_W-1:0] r_digit_idx;
  logic             r_blink_phase;
  logic [3:0]       w_sel;
  logic             w_non_bcd;
  logic             w_blank;
  logic [NUM_DIGITS-1:0] r_an;
  logic             r_dp;
  logic [3:0]       r_bcd;

  // Slot prescaler: free-running, terminal count marks the end of a slot.
  mod_counter #(.MOD(SCAN_DIV), .W(PRE_W)) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .i_en    (1'b1),
    .o_count (w_pre_cnt),
    .o_tc    (w_slot_tick)
  );

  // Blink counter: counts completed slots, wraps once per blink half-period.
  mod_counter #(.MOD(BLINK_DIV), .W(BLK_W)) u_blink_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_slot_tick),
    .o_count (w_unused_blink_cnt),
    .o_tc    (w_blink_wrap)
  );

  assign w_sel     = digits[{r_digit_idx, 2'b00} +: 4];
  assign w_non_bcd = (w_sel > BCD_MAX);
  assign w_blank   = (w_pre_cnt < BLANK_END) || !enable ||
                     (blink_mask[r_digit_idx] && r_blink_phase) || w_non_bcd;

  // Step to the next digit on each slot tick; toggle the shared blink phase on wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_digit_idx   <= '0;
      r_blink_phase <= 1'b0;
    end else begin
      if (w_slot_tick) begin
        r_digit_idx <= r_digit_idx + IDX_W'(1);
      end
      if (w_blink_wrap) begin
        r_blink_phase <= ~r_blink_phase;
      end
    end
  end

  // Register display outputs; bcd_out settles during blanking so the decoder is ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_an  <= AN_OFF;
      r_dp  <= DP_OFF;
      r_bcd <= 4'h0;
    end else begin
      r_an  <= w_blank ? AN_OFF : anode_sel(r_digit_idx);
      r_dp  <= w_blank ? DP_OFF : ~dp_mask[r_digit_idx];
      r_bcd <= w_non_bcd ? 4'h0 : w_sel;
    end
  end

  assign an        = r_an;
  assign dp        = r_dp;
  assign bcd_out   = r_bcd;
  assign digit_idx = r_digit_idx;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux with a short scan (8 cycles/slot, 2 blank, 4 slots/blink half).
// A cycle-indexed reference model pushes the expected outputs every clock edge;
// a monitor pops and compares on the falling edge. Directed checks add hand values.
module tb_seg7_scan_mux;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BD = 4;

  typedef struct packed {
    logic [3:0] an;
    logic       dp;
    logic [3:0] bcd;
    logic [1:0] idx;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  blink_mask;
  logic [3:0]  dp_mask;
  logic        enable;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic        dp;
  logic [1:0]  digit_idx;

  exp_t q[$];
  int   n_total = 0;
  int   n_bad   = 0;
  int   n_cyc   = 0;

  seg7_scan_mux #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
    .clk        (clk),
    .rst        (rst),
    .digits     (digits),
    .blink_mask (blink_mask),
    .dp_mask    (dp_mask),
    .enable     (enable),
    .bcd_out    (bcd_out),
    .an         (an),
    .dp         (dp),
    .digit_idx  (digit_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int got, input int req);
    n_total++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h at %0t", nm, got, req, $time);
    end
  endtask

  // Reference model: state is the cycle count since reset, decoded arithmetically.
  always @(posedge clk) begin
    exp_t e;
    int pre, slot, idx, ph, sel;
    bit nb, blank;
    if (rst) begin
      e = '{an: 4'hF, dp: 1'b1, bcd: 4'h0, idx: 2'd0};
      n_cyc = 0;
    end else begin
      pre   = n_cyc % SD;
      slot  = n_cyc / SD;
      idx   = slot % 4;
      ph    = (slot / BD) % 2;
      sel   = (int'(digits) >> (4 * idx)) & 15;
      nb    = (sel > 9);
      blank = (pre < BC) || !enable || (blink_mask[idx] && ph == 1) || nb;
      e.an  = blank ? 4'hF : 4'(15 - (1 << idx));
      e.dp  = blank ? 1'b1 : ~dp_mask[idx];
      e.bcd = nb ? 4'h0 : 4'(sel);
      e.idx = 2'(((n_cyc + 1) / SD) % 4);
      n_cyc++;
    end
    q.push_back(e);
  end

  // Monitor: every cycle is an output beat.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("sb_an", int'(an), int'(e.an));
      chk("sb_dp", int'(dp), int'(e.dp));
      chk("sb_bcd", int'(bcd_out), int'(e.bcd));
      chk("sb_idx", int'(digit_idx), int'(e.idx));
    end
  end

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    digits     = 16'h1234;
    blink_mask = 4'b0000;
    dp_mask    = 4'b0000;
    enable     = 1'b1;
    tick(2);
    rst = 1'b0;

    // Scan order and anti-ghosting blanking.
    tick(2);  @(negedge clk); chk("rel_blank", an, 4'b1111);
    tick(1);  @(negedge clk); chk("d0_lit", an, 4'b1110); chk("d0_bcd", bcd_out, 4'h4);
    tick(5);  @(negedge clk); chk("idx_1", digit_idx, 2'd1); chk("d0_last", an, 4'b1110);
    tick(1);  @(negedge clk); chk("d1_blank", an, 4'b1111); chk("d1_bcd_early", bcd_out, 4'h3);
    tick(2);  @(negedge clk); chk("d1_lit", an, 4'b1101);
    tick(53);

    // Blink on digit 0 from a fresh phase.
    blink_mask = 4'b0001;
    do_reset();
    tick(3);  @(negedge clk); chk("blink_on", an, 4'b1110);
    tick(32); @(negedge clk); chk("blink_off", an, 4'b1111);
    tick(8);  @(negedge clk); chk("blink_d1", an, 4'b1101);
    tick(85);

    // Non-BCD digit and decimal point.
    blink_mask = 4'b0000;
    digits     = 16'h9A05;
    dp_mask    = 4'b0100;
    do_reset();
    tick(11); @(negedge clk); chk("nb_d1", an, 4'b1101); chk("nb_d1_dp", dp, 1'b1);
    tick(9);  @(negedge clk); chk("nb_an", an, 4'b1111); chk("nb_bcd", bcd_out, 4'h0);
    chk("nb_dp", dp, 1'b1);
    tick(7);  @(negedge clk); chk("d3_an", an, 4'b0111); chk("d3_bcd", bcd_out, 4'h9);
    tick(5);
    digits = 16'h9805;
    do_reset();
    tick(20); @(negedge clk); chk("d2_an", an, 4'b1011); chk("d2_dp", dp, 1'b0);
    chk("d2_bcd", bcd_out, 4'h8);
    tick(12);

    // Display disabled: counters keep running, outputs dark.
    digits  = 16'h1234;
    dp_mask = 4'b1111;
    enable  = 1'b0;
    do_reset();
    tick(8);  @(negedge clk); chk("dis_idx1", digit_idx, 2'd1);
    tick(8);  @(negedge clk); chk("dis_idx2", digit_idx, 2'd2);
    chk("dis_an", an, 4'b1111); chk("dis_dp", dp, 1'b1);
    tick(24);
    enable = 1'b1;
    tick(16);

    // Reset asserted mid slot 2.
    dp_mask = 4'b0000;
    do_reset();
    tick(20); @(negedge clk); chk("pre_rst_idx", digit_idx, 2'd2);
    rst = 1'b1;
    tick(1);  @(negedge clk); chk("rst_idx", digit_idx, 2'd0);
    chk("rst_an", an, 4'b1111); chk("rst_bcd", bcd_out, 4'h0);
    rst = 1'b0;
    tick(2);  @(negedge clk); chk("post_blank", an, 4'b1111);
    tick(1);  @(negedge clk); chk("post_lit", an, 4'b1110);
    tick(4);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Time-multiplexes four BCD digits onto one shared 4-digit common-anode 7-segment display.
- Each scan slot presents one digit on bcd_out, which feeds the BCD-to-7-segment decoder directly.
- Drives the active-low anode and decimal-point lines.
- Provides per-digit blinking (alarm/time-set mode), decimal points, anti-ghosting blanking and whole-display enable.

Parameters:
- SCAN_DIV, 50000: clk cycles per digit slot (1 kHz slot rate at 50 MHz); must be >= 2.
- BLANK_CYC, 500: cycles at the start of each slot during which all anodes are off; must be < SCAN_DIV.
- BLINK_DIV, 250: completed slots per blink half-period (250 ms at defaults); must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- digits  in  16  digit i occupies [4i+3:4i]; digit 0 is the rightmost.
- blink_mask  in  4  1 = digit i blinks.
- dp_mask  in  4  1 = decimal point lit on digit i.
- enable  in  1  0 = whole display dark.
- bcd_out  out  4  BCD value of the active digit, to the decoder.
- an  out  4  anode enables, active-low; an[i] = digit i.
- dp  out  1  decimal point, active-low.
- digit_idx  out  2  index of the current slot.

Behaviour:
- One clock domain. Reset is synchronous and active-high: sampled only on the rising edge of clk.
- Reset values: pre_cnt=0, digit_idx=0, blink_cnt=0, blink_phase=0 (visible), an=4'b1111, dp=1, bcd_out=4'h0.
- Prescaler pre_cnt counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and asserts a one-cycle slot tick.
  - On a slot tick, digit_idx increments mod 4 (3 wraps to 0).
- Blink counter blink_cnt advances on each slot tick, counting 0..BLINK_DIV-1.
  - At BLINK_DIV-1 with a slot tick, it wraps to 0 and toggles blink_phase.
- Blank condition for the current slot is the OR of:
  - pre_cnt < BLANK_CYC (anti-ghosting window);
  - enable=0;
  - blink_mask[idx]=1 and blink_phase=1;
  - the selected digit value > 9 (non-BCD). This keeps the decoder from ever showing an undefined pattern.
- Outputs are registered: an, dp and bcd_out at cycle t+1 reflect state and inputs at cycle t.
  - Latency from any input change to the outputs is exactly 1 cycle.
  - digit_idx is the state register itself, not delayed.
- When not blanked: an = ~(4'b0001 << idx) and dp = ~dp_mask[idx].
- When blanked: an = 4'b1111 and dp = 1.
- bcd_out:
  - Always the selected digit value when it is <= 9, even while blanked, so the decoder output is settled before the anode turns on.
  - 4'h0 when the selected digit is > 9.
- Inputs are not captured. A digit change mid-slot appears on bcd_out one cycle later; no tearing logic.
- Reset asserted mid-scan: all state returns to reset values on the next edge and the display goes dark. After release, digit 0 lights after BLANK_CYC cycles.
- Blink phase is common to all digits, so blinking digits flash in unison. Toggling blink_mask does not reset the phase.
- enable=0 leaves counters running, so scan and blink phase stay continuous.

Decomposition:
- Shared package seg7_pkg holds:
  - AN_OFF = 4'b1111 and DP_OFF = 1'b1;
  - NUM_DIGITS = 4;
  - BCD_MAX = 4'd9.
- One natural sub-module, mod_counter: parameterised modulus counter with enable, synchronous reset and a terminal-count pulse. It is instantiated twice, for the prescaler (enable=1) and the blink counter (enable = slot tick).

Test Plan (SCAN_DIV=8, BLANK_CYC=2, BLINK_DIV=4):
- Scan order:
  - Stimulus: digits=16'h1234, enable=1, masks 0, release reset.
  - Required: digit_idx steps 0,1,2,3,0 every 8 cycles; bcd_out 4,3,2,1.
  - Required: an = 1111 for 2 cycles, then 1110 / 1101 / 1011 / 0111 for 6 cycles each.
- Anti-ghosting: at every digit_idx change, an = 4'b1111 for exactly 2 cycles before the new anode goes low; bcd_out already holds the new digit during those cycles.
- Blink:
  - Stimulus: blink_mask=4'b0001.
  - Required: digit 0 lit during slots 0-3, dark (an=1111) during slots 4-7, period 64 cycles.
  - Required: digits 1-3 are never blanked by blink.
- Non-BCD and decimal point:
  - Stimulus: digits=16'h9A05, dp_mask=4'b0100.
  - Required: digit 2 slot has an=1111 and bcd_out=0.
  - Required: every other slot keeps dp=1; digit 3 shows bcd_out=9.
  - Rerun with digits=16'h9805: digit 2 shows an=1011 and dp=0 after blanking.
- Enable and reset:
  - Stimulus: enable=0 for 40 cycles -> an=1111 and dp=1 throughout while digit_idx keeps counting.
  - Stimulus: assert rst mid-slot 2 -> next edge gives digit_idx=0, an=1111, bcd_out=0.
  - Required after release: digit 0 lights 2 cycles after release.
